ram_copier: RTL and testbench

RAM_COPIER -- requirements
Module: ram_copier

---
 rtl/ram_copier_if.sv | 24 ++
 rtl/ram_copier.sv | 70 +++++++
 tb/tb_ram_copier.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ram_copier_if.sv
// ram_copier_if: copy-request handshake plus the single-port RAM bus of the copier.
interface ram_copier_if #(
    parameter int ADDRWIDTH = 6,
    parameter int DATAWIDTH = 32
);
    logic                 iStart;
    logic [ADDRWIDTH-1:0] iSrc;
    logic [ADDRWIDTH-1:0] iDst;
    logic [ADDRWIDTH:0]   iLen;
    logic                 oBusy;
    logic                 oDone;
    logic                 oMemWR;
    logic [ADDRWIDTH-1:0] oMemAddress;
    logic [DATAWIDTH-1:0] oMemWriteData;
    logic [DATAWIDTH-1:0] iMemReadData;
    modport slave (
        input  iStart, iSrc, iDst, iLen, iMemReadData,
        output oBusy, oDone, oMemWR, oMemAddress, oMemWriteData
    );
    modport master (
        output iStart, iSrc, iDst, iLen, iMemReadData,
        input  oBusy, oDone, oMemWR, oMemAddress, oMemWriteData
    );
endinterface

// File: rtl/ram_copier.sv
// ram_copier: memmove-style word copier over a single-port RAM with combinational read,
// one READ/WRITE cycle pair per word, descending when the destination lies above the source.
module ram_copier #(
    parameter int ADDRWIDTH = 6,
    parameter int DATAWIDTH = 32
) (
    input  logic         iClk,
    input  logic         iRst_n,
    ram_copier_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]           r_state;
    logic [ADDRWIDTH-1:0] r_src;
    logic [ADDRWIDTH-1:0] r_dst;
    logic [ADDRWIDTH:0]   r_cnt;
    logic [DATAWIDTH-1:0] r_data;
    logic                 r_desc;
    logic                 w_desc;
    logic [ADDRWIDTH-1:0] w_off;
    logic [ADDRWIDTH-1:0] w_step;

    assign w_desc = bus.iDst > bus.iSrc;
    assign w_off  = ADDRWIDTH'(bus.iLen - 1'b1);
    // adding all-ones steps the pointers down by one, modulo the memory depth
    assign w_step = r_desc ? '1 : ADDRWIDTH'(1);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_desc  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.iStart) begin
                    r_state <= (bus.iLen == '0) ? DONE : READ;
                    if (bus.iLen != '0) begin
                        r_desc <= w_desc;
                        r_src  <= w_desc ? bus.iSrc + w_off : bus.iSrc;
                        r_dst  <= w_desc ? bus.iDst + w_off : bus.iDst;
                        r_cnt  <= bus.iLen;
                    end
                end
                READ: begin
                    r_data  <= bus.iMemReadData;
                    r_state <= WRITE;
                end
                WRITE: begin
                    r_cnt   <= r_cnt - 1'b1;
                    r_src   <= r_src + w_step;
                    r_dst   <= r_dst + w_step;
                    r_state <= (r_cnt > 1) ? READ : DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.oBusy         = r_state != IDLE;
    assign bus.oDone         = r_state == DONE;
    assign bus.oMemWR        = r_state == WRITE;
    assign bus.oMemAddress   = (r_state == READ) ? r_src : (r_state == WRITE) ? r_dst : '0;
    assign bus.oMemWriteData = r_data;
endmodule

// File: tb/tb_ram_copier.sv
// tb_ram_copier: directed checks of ram_copier against a behavioural RAM and hand-computed results.
module tb_ram_copier;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic do_preload = 1'b0;
    logic [31:0] mem [64];
    int n_chk = 0;
    int n_fail = 0;
    int done_cyc, n_done, nwr, nrd;
    int wa [70];
    int ra [70];

    always #5 clk = ~clk;

    ram_copier_if #(.ADDRWIDTH(6), .DATAWIDTH(32)) mif ();

    ram_copier #(.ADDRWIDTH(6), .DATAWIDTH(32)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (mif)
    );

    assign mif.iMemReadData = mem[mif.oMemAddress];

    always @(posedge clk) begin
        if (do_preload)
            for (int k = 0; k < 64; k++) mem[k] <= 32'(k + 32'h100);
        else if (mif.oMemWR)
            mem[mif.oMemAddress] <= mif.oMemWriteData;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload();
        @(negedge clk);
        do_preload = 1'b1;
        @(negedge clk);
        do_preload = 1'b0;
    endtask

    // Cycle k counts negedges after the iStart sampling edge; a restart pulse can be injected at rs_at.
    task automatic run_copy(input int src, input int dst, input int len, input int rs_at);
        done_cyc = -1; n_done = 0; nwr = 0; nrd = 0;
        @(negedge clk);
        mif.iStart = 1'b1; mif.iSrc = 6'(src); mif.iDst = 6'(dst); mif.iLen = 7'(len);
        @(posedge clk);
        for (int k = 1; k <= 2 * len + 5; k++) begin
            @(negedge clk);
            if (mif.oDone) begin n_done++; if (done_cyc < 0) done_cyc = k; end
            if (mif.oMemWR && nwr < 70) begin wa[nwr] = int'(mif.oMemAddress); nwr++; end
            if (mif.oBusy && !mif.oMemWR && !mif.oDone && nrd < 70) begin ra[nrd] = int'(mif.oMemAddress); nrd++; end
            if (k == rs_at) begin
                mif.iStart = 1'b1; mif.iSrc = 6'd0; mif.iDst = 6'd40; mif.iLen = 7'd2;
            end else mif.iStart = 1'b0;
        end
    endtask

    initial begin
        mif.iStart = 1'b0; mif.iSrc = '0; mif.iDst = '0; mif.iLen = '0;
        #1;
        chk("rst_busy", mif.oBusy, 0);
        chk("rst_done", mif.oDone, 0);
        chk("rst_wr", mif.oMemWR, 0);
        chk("rst_addr", mif.oMemAddress, 0);
        chk("rst_wdata", mif.oMemWriteData, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        preload();
        run_copy(4, 20, 3, -1);
        chk("d3_done_cyc", done_cyc, 7);
        chk("d3_pulses", n_done, 1);
        chk("d3_nwr", nwr, 3);
        chk("d3_wa0", wa[0], 22);
        chk("d3_wa1", wa[1], 21);
        chk("d3_wa2", wa[2], 20);
        chk("d3_mem20", mem[20], 32'h104);
        chk("d3_mem21", mem[21], 32'h105);
        chk("d3_mem22", mem[22], 32'h106);
        chk("idle_addr", mif.oMemAddress, 0);
        chk("idle_wdata", mif.oMemWriteData, 32'h104);

        preload();
        run_copy(10, 12, 4, -1);
        chk("ovd_done_cyc", done_cyc, 9);
        chk("ovd_mem12", mem[12], 32'h10A);
        chk("ovd_mem13", mem[13], 32'h10B);
        chk("ovd_mem14", mem[14], 32'h10C);
        chk("ovd_mem15", mem[15], 32'h10D);
        run_copy(12, 10, 4, -1);
        chk("ova_wa0", wa[0], 10);
        chk("ova_mem10", mem[10], 32'h10A);
        chk("ova_mem11", mem[11], 32'h10B);
        chk("ova_mem12", mem[12], 32'h10C);
        chk("ova_mem13", mem[13], 32'h10D);

        preload();
        run_copy(62, 0, 3, -1);
        chk("wrap_ra1", ra[1], 63);
        chk("wrap_ra2", ra[2], 0);
        chk("wrap_mem0", mem[0], 32'h13E);
        chk("wrap_mem1", mem[1], 32'h13F);

        run_copy(5, 9, 0, -1);
        chk("len0_done_cyc", done_cyc, 1);
        chk("len0_pulses", n_done, 1);
        chk("len0_nwr", nwr, 0);

        preload();
        run_copy(0, 0, 64, -1);
        chk("full_done_cyc", done_cyc, 129);
        chk("full_nwr", nwr, 64);
        chk("full_mem0", mem[0], 32'h100);
        chk("full_mem63", mem[63], 32'h13F);

        preload();
        run_copy(1, 30, 5, 3);
        chk("rs_nwr", nwr, 5);
        chk("rs_pulses", n_done, 1);
        chk("rs_done_cyc", done_cyc, 11);
        chk("rs_mem30", mem[30], 32'h101);
        chk("rs_mem34", mem[34], 32'h105);
        chk("rs_mem40", mem[40], 32'h128);

        preload();
        @(negedge clk);
        mif.iStart = 1'b1; mif.iSrc = 6'd50; mif.iDst = 6'd40; mif.iLen = 7'd4;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            mif.iStart = 1'b0;
        end
        chk("ab_wr_before", mif.oMemWR, 1);
        chk("ab_addr_before", mif.oMemAddress, 41);
        rst_n = 1'b0;
        #1;
        chk("ab_wr", mif.oMemWR, 0);
        chk("ab_busy", mif.oBusy, 0);
        chk("ab_addr", mif.oMemAddress, 0);
        repeat (3) @(negedge clk);
        chk("ab_mem40", mem[40], 32'h132);
        chk("ab_mem41", mem[41], 32'h129);
        rst_n = 1'b1;
        run_copy(0, 60, 1, -1);
        chk("post_done_cyc", done_cyc, 3);
        chk("post_mem60", mem[60], 32'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
